// File: rtl/gol_controller_if.sv
// Bundle of control, status and grid-compare signals exchanged between the
// Game-of-Life sequencer and the surrounding datapath/user controls.
interface gol_controller_if #(
    parameter int GEN_W = 16
);
    logic             start;
    logic             pause;
    logic             step;
    logic [63:0]      grid;
    logic [63:0]      grid_next;
    logic             lfsr_reset;
    logic             sel_lfsr;
    logic             en;
    logic [GEN_W-1:0] gen_count;
    logic             running;
    logic             halted;
    logic             extinct;

    modport master (
        output start, pause, step, grid, grid_next,
        input  lfsr_reset, sel_lfsr, en, gen_count, running, halted, extinct
    );

    modport slave (
        input  start, pause, step, grid, grid_next,
        output lfsr_reset, sel_lfsr, en, gen_count, running, halted, extinct
    );
endinterface

// File: rtl/gol_controller.sv
// Sequencer for an 8x8 Game-of-Life grid: seeds the grid from a free-running
// LFSR, then evolves it at a fixed generation rate until it stops changing.
// Supports pause/single-step and restart from any active state.
module gol_controller #(
    parameter int SEED_CYCLES = 8,
    parameter int DIV_MAX     = 5_000_000,
    parameter int GEN_W       = 16
) (
    input logic          clk,
    input logic          reset,
    gol_controller_if.slave ctl
);

    localparam logic [7:0]  SEED_LAST = 8'(SEED_CYCLES - 1);
    localparam logic [23:0] DIV_LAST  = 24'(DIV_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        LOAD,
        RUN,
        PAUSE,
        HALT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       seed_q, seed_d;
    logic [23:0]      div_q, div_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             halted_q, halted_d;
    logic             extinct_q, extinct_d;
    logic             lfsr_reset_q;
    logic             running_q;

    logic             changed;
    logic             evolve;
    logic             load_cycle;
    logic             en_c;
    logic             sel_c;

    // Next-state logic; en/sel_lfsr are decoded here combinationally so an
    // evolve slot can skip the write when the grid has stopped changing.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        div_d     = div_q;
        gen_d     = gen_q;
        halted_d  = halted_q;
        extinct_d = extinct_q;

        changed    = (ctl.grid_next != ctl.grid);
        load_cycle = (state_q == LOAD);
        evolve     = !ctl.start &&
                     (((state_q == RUN) && (div_q == DIV_LAST)) ||
                      ((state_q == PAUSE) && ctl.step && !ctl.pause));
        en_c       = load_cycle || (evolve && changed);
        sel_c      = load_cycle;

        if (ctl.start && (state_q != IDLE)) begin
            state_d   = SEED;
            seed_d    = '0;
            halted_d  = 1'b0;
            extinct_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctl.start) begin
                        state_d = SEED;
                        seed_d  = '0;
                    end
                end
                SEED: begin
                    if (seed_q == SEED_LAST) begin
                        state_d = LOAD;
                    end else begin
                        seed_d = seed_q + 8'd1;
                    end
                end
                LOAD: begin
                    gen_d   = '0;
                    div_d   = '0;
                    state_d = RUN;
                end
                RUN: begin
                    if (evolve) begin
                        div_d = '0;
                        if (!changed) begin
                            state_d   = HALT;
                            halted_d  = 1'b1;
                            extinct_d = (ctl.grid == '0);
                        end else begin
                            if (gen_q != '1) begin
                                gen_d = gen_q + GEN_W'(1);
                            end
                            if (ctl.pause) begin
                                state_d = PAUSE;
                            end
                        end
                    end else if (ctl.pause) begin
                        state_d = PAUSE;
                    end else begin
                        div_d = div_q + 24'd1;
                    end
                end
                PAUSE: begin
                    if (ctl.pause) begin
                        state_d = RUN;
                    end else if (evolve) begin
                        if (!changed) begin
                            state_d   = HALT;
                            halted_d  = 1'b1;
                            extinct_d = (ctl.grid == '0);
                        end else if (gen_q != '1) begin
                            gen_d = gen_q + GEN_W'(1);
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and counter registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            seed_q       <= '0;
            div_q        <= '0;
            gen_q        <= '0;
            halted_q     <= 1'b0;
            extinct_q    <= 1'b0;
            lfsr_reset_q <= 1'b1;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            div_q        <= div_d;
            gen_q        <= gen_d;
            halted_q     <= halted_d;
            extinct_q    <= extinct_d;
            lfsr_reset_q <= (state_d == IDLE);
            running_q    <= (state_d == RUN);
        end
    end

    assign ctl.en         = en_c;
    assign ctl.sel_lfsr   = sel_c;
    assign ctl.lfsr_reset = lfsr_reset_q;
    assign ctl.running    = running_q;
    assign ctl.gen_count  = gen_q;
    assign ctl.halted     = halted_q;
    assign ctl.extinct    = extinct_q;

endmodule

// File: doc/gol_controller.md
GOL_CONTROLLER -- requirements
Module: gol_controller

Interface
REQ-001 Parameter SEED_CYCLES, default 8: clock cycles the LFSR free-runs before each grid load; legal range 1 to 255.
REQ-002 Parameter DIV_MAX, default 5_000_000: clock cycles per generation in RUN; legal range 2 to 2^24-1.
REQ-003 Parameter GEN_W, default 16: width of the generation counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  pulse; begins (or restarts) seeding.
REQ-007 pause  in  1  pulse; toggles RUN and PAUSE.
REQ-008 step  in  1  pulse; single generation while in PAUSE.
REQ-009 grid  in  64  current grid register contents.
REQ-010 grid_next  in  64  datapath next-generation result for grid.
REQ-011 lfsr_reset  out  1  active-high; holds the LFSR at its seed.
REQ-012 sel_lfsr  out  1  grid mux select; 1 = load LFSR output, 0 = load grid_next.
REQ-013 en  out  1  grid register enable.
REQ-014 gen_count  out  GEN_W  generations evolved since last load.
REQ-015 running, halted, extinct  out  1 each  status flags.

Function
REQ-016 States SHALL be IDLE, SEED, LOAD, RUN, PAUSE, HALT, held in one state register.
REQ-017 IDLE: lfsr_reset=1, en=0; start -> SEED.
REQ-018 SEED: lfsr_reset=0; a seed counter SHALL count SEED_CYCLES cycles, then go to LOAD.
REQ-019 LOAD: lasts exactly one cycle with en=1 and sel_lfsr=1; it SHALL clear gen_count and the divider to 0, then go to RUN.
REQ-020 RUN: divider SHALL increment each cycle; the cycle with divider==DIV_MAX-1 is an evolve slot, and the divider wraps to 0 after it.
REQ-021 An evolve slot SHALL compare grid_next with grid combinationally in that cycle.
REQ-022 Evolve slot, grid_next != grid: en=1, sel_lfsr=0, gen_count increments, saturating at all-ones.
REQ-023 Evolve slot, grid_next == grid: en=0, gen_count held; go to HALT with halted=1 and extinct=(grid==0).
REQ-024 en and sel_lfsr SHALL be combinational from state, divider and compare; all other outputs SHALL be registered.
REQ-025 RUN, pause: go to PAUSE with the divider held; pause coincident with an evolve slot SHALL perform the evolve and then enter PAUSE.
REQ-026 PAUSE: step SHALL make that same cycle an evolve slot (rules REQ-021 to REQ-023) without changing the divider, staying in PAUSE unless it halts.
REQ-027 PAUSE: pause -> RUN, resuming from the held divider value; pause together with step SHALL ignore step.
REQ-028 start in SEED, LOAD, RUN, PAUSE or HALT SHALL go to SEED, clear the seed counter, halted and extinct, and take priority over pause and step.
REQ-029 lfsr_reset SHALL be 1 only in IDLE; the LFSR keeps running through a restart from HALT.
REQ-030 running SHALL be 1 exactly when the state is RUN.
REQ-031 step outside PAUSE and pause outside RUN/PAUSE SHALL be ignored.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE, overriding all inputs in any state.
REQ-033 reset SHALL clear the seed counter, divider, gen_count, halted and extinct to 0.
REQ-034 reset SHALL give outputs lfsr_reset=1, sel_lfsr=0, en=0, running=0.

Verification (SEED_CYCLES=3, DIV_MAX=4, GEN_W=16)
REQ-035 Reset mid-run: reset low 1 cycle in RUN with gen_count=5 -> IDLE next edge, gen_count=0, en=0, lfsr_reset=1.
REQ-036 Start from IDLE: start pulse -> lfsr_reset=0 for 3 SEED cycles, then exactly one cycle with en=1 and sel_lfsr=1, then running=1.
REQ-037 Blinker: grid=64'h0000_0000_0038_0000 with grid_next differing -> en=1 and sel_lfsr=0 every 4th cycle; gen_count reads 1, 2, 3.
REQ-038 Still life: grid=grid_next=64'h0000_0018_1800_0000 -> at the first evolve slot en=0, halted=1, extinct=0; with grid=grid_next=0 -> extinct=1.
REQ-039 Pause and step: pause at divider=2 and hold 10 cycles -> no en; step -> en=1 that cycle, gen_count+1; pause -> en on the 2nd cycle after resume.
REQ-040 Conflicts: start while paused -> SEED next edge, halted=0; pause+step together in PAUSE -> RUN, no en that cycle; gen_count at 16'hFFFF plus another evolve -> stays 16'hFFFF.
